// File: rtl/iic_pkg.sv
// Shared types and constants for the I2C register target.
package iic_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } iic_tgt_state_t;

  localparam logic [6:0] HDMI_IIC_ADDR = 7'b1110110;
  localparam logic       IIC_RW_WRITE  = 1'b0;
  localparam logic       IIC_RW_READ   = 1'b1;

endpackage

// File: rtl/iic_line_sync.sv
// Synchronises raw SCL/SDA pins and produces registered edge and bus-condition pulses.
module iic_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0] first sync stage, [1] second sync stage, [2] history
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       scl_rise_q, scl_fall_q, start_q, stop_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // Reset to the idle bus level so a quiet bus produces no spurious edges
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_q      <= {scl_q[1:0], scl_in};
      sda_q      <= {sda_q[1:0], sda_in};
      scl_rise_q <= scl_q[1] & ~scl_q[2];
      scl_fall_q <= ~scl_q[1] & scl_q[2];
      start_q    <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
      stop_q     <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign sda_s     = sda_q[2];

endmodule

// File: rtl/iic_target_regs.sv
// I2C target with a byte-wide register file: bus pointer/write/read plus fabric read port.
module iic_target_regs
  import iic_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = HDMI_IIC_ADDR,
  parameter int unsigned DEPTH      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  iic_line_sync u_line_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  iic_tgt_state_t state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     ptr_q, ptr_d;
  logic           rw_q, rw_d;
  logic           oe_q, oe_d;
  logic           busy_q, busy_d;
  logic           wr_valid_q, wr_valid_d;
  logic [7:0]     wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;
  logic [7:0]     regs_q [DEPTH];

  logic       reg_we;
  logic [7:0] byte_in;
  logic [7:0] rd_byte;
  logic       ptr_in_range;
  logic       rd_in_range;

  assign byte_in      = {shift_q[6:0], sda_s};
  assign ptr_in_range = 32'(ptr_q) < DEPTH;
  assign rd_in_range  = 32'(rd_addr) < DEPTH;
  assign rd_byte      = ptr_in_range ? regs_q[ptr_q[AW-1:0]] : 8'h00;
  assign rd_data      = rd_in_range ? regs_q[rd_addr[AW-1:0]] : 8'h00;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    reg_we     = 1'b0;

    if (stop_det) begin
      state_d = StIdle;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (state_q == StAddr) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                busy_d  = 1'b1;
                rw_d    = byte_in[0];
                state_d = StAddrAck;
              end else begin
                busy_d  = 1'b0;
                state_d = StIgnore;
              end
            end else if (state_q == StPtr) begin
              ptr_d   = byte_in;
              state_d = StPtrAck;
            end else begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = byte_in;
              reg_we     = ptr_in_range;
              ptr_d      = ptr_q + 8'd1;
              state_d    = StWdataAck;
            end
          end
        end
        // Ninth rise: mark the ACK bit as clocked so the next fall releases SDA
        StAddrAck, StPtrAck, StWdataAck: cnt_d = 4'd1;
        StRdataAck: begin
          ptr_d = ptr_q + 8'd1;
          if (sda_s) begin
            state_d = StIgnore;
          end else begin
            cnt_d = 4'd1;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        StAddrAck: begin
          if (cnt_q == 4'd0) begin
            oe_d = 1'b1;
          end else if (rw_q == IIC_RW_READ) begin
            shift_d = {rd_byte[6:0], 1'b0};
            oe_d    = ~rd_byte[7];
            cnt_d   = 4'd1;
            state_d = StRdata;
          end else begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = StPtr;
          end
        end
        StPtrAck, StWdataAck: begin
          if (cnt_q == 4'd0) begin
            oe_d = 1'b1;
          end else begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = StWdata;
          end
        end
        StRdata: begin
          if (cnt_q == 4'd8) begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = StRdataAck;
          end else begin
            oe_d    = ~shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end
        end
        StRdataAck: begin
          if (cnt_q == 4'd1) begin
            shift_d = {rd_byte[6:0], 1'b0};
            oe_d    = ~rd_byte[7];
            cnt_d   = 4'd1;
            state_d = StRdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= IIC_RW_WRITE;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we) begin
      regs_q[ptr_q[AW-1:0]] <= byte_in;
    end
  end

  assign sda_oe   = oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_iic_target_regs.sv
// Pin-level I2C master driving iic_target_regs, checked against a register-file model.
module tb_iic_target_regs;
  import iic_pkg::*;

  localparam int         H     = 12;
  localparam int         DEPTH = 64;
  localparam logic [6:0] SA    = HDMI_IIC_ADDR;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       sda_line;
  logic       sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data, rd_data;
  logic [7:0] rd_addr = 8'h00;

  assign sda_line = ~(m_low | sda_oe);

  always #5 clk = ~clk;

  iic_target_regs #(
    .SLAVE_ADDR(SA),
    .DEPTH     (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl),
    .sda_in  (sda_line),
    .sda_oe  (sda_oe),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] mem [256];
  logic [7:0] ptr = 8'h00;
  logic [15:0] wq[$];
  int         oe_cnt = 0;
  int         busy_cnt = 0;

  always @(posedge clk) begin
    if (wr_valid) wq.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    return (32'(a) < DEPTH) ? mem[a] : 8'h00;
  endfunction

  // One SCL period entered with SCL low; returns SDA sampled mid-high
  task automatic bit_out(input logic b, output logic line);
    m_low = ~b;
    clk_n(H - 4);
    scl = 1'b1;
    clk_n(H / 2);
    line = sda_line;
    clk_n(H / 2);
    scl = 1'b0;
    clk_n(4);
  endtask

  task automatic bus_start();
    m_low = 1'b1;
    clk_n(H);
    scl = 1'b0;
    clk_n(4);
  endtask

  task automatic bus_rstart();
    m_low = 1'b0;
    clk_n(H - 4);
    scl = 1'b1;
    clk_n(H);
    m_low = 1'b1;
    clk_n(H);
    scl = 1'b0;
    clk_n(4);
  endtask

  task automatic bus_stop();
    m_low = 1'b1;
    clk_n(H - 4);
    scl = 1'b1;
    clk_n(H);
    m_low = 1'b0;
    clk_n(2 * H);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) bit_out(b[i], l);
    bit_out(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic l;
    for (int i = 0; i < 8; i++) begin
      bit_out(1'b1, l);
      b = {b[6:0], l};
    end
    bit_out(mack, l);
  endtask

  task automatic wr_txn(input logic [7:0] p, input int n, input logic [7:0] d[8]);
    logic        a;
    int          base;
    logic [15:0] ex[8];
    base = wq.size();
    bus_start();
    send_byte({SA, IIC_RW_WRITE}, a);
    chk("wr_addr_ack", 32'(a), 32'(0));
    chk("wr_busy", 32'(busy), 32'(1));
    send_byte(p, a);
    chk("wr_ptr_ack", 32'(a), 32'(0));
    ptr = p;
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], a);
      chk("wr_data_ack", 32'(a), 32'(0));
      ex[i] = {ptr, d[i]};
      if (32'(ptr) < DEPTH) mem[ptr] = d[i];
      ptr = ptr + 8'd1;
    end
    bus_stop();
    chk("wr_stop_oe", 32'(sda_oe), 32'(0));
    chk("wr_stop_busy", 32'(busy), 32'(0));
    chk("wr_strobe_cnt", 32'(wq.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < wq.size(); i++) begin
      chk("wr_strobe", 32'(wq[base+i]), 32'(ex[i]));
    end
  endtask

  // set_ptr=0 reads from the current pointer without a pointer write
  task automatic rd_txn(input logic set_ptr, input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] b;
    int         base;
    base = wq.size();
    bus_start();
    if (set_ptr) begin
      send_byte({SA, IIC_RW_WRITE}, a);
      chk("rd_waddr_ack", 32'(a), 32'(0));
      send_byte(p, a);
      chk("rd_ptr_ack", 32'(a), 32'(0));
      ptr = p;
      bus_rstart();
    end
    send_byte({SA, IIC_RW_READ}, a);
    chk("rd_addr_ack", 32'(a), 32'(0));
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? 1'b1 : 1'b0, b);
      chk("rd_byte", 32'(b), 32'(model_rd(ptr)));
      ptr = ptr + 8'd1;
    end
    bus_stop();
    chk("rd_stop_oe", 32'(sda_oe), 32'(0));
    chk("rd_stop_busy", 32'(busy), 32'(0));
    chk("rd_no_strobe", 32'(wq.size() - base), 32'(0));
  endtask

  task automatic chk_regs();
    for (int a = 0; a < 72; a++) begin
      rd_addr = 8'(a);
      #1;
      chk("rd_port", 32'(rd_data), 32'(model_rd(8'(a))));
    end
    rd_addr = 8'hFF;
    #1;
    chk("rd_port_ff", 32'(rd_data), 32'(0));
  endtask

  initial begin
    logic [7:0] d[8];
    logic       a;
    int         base, oe0, busy0;
    logic       l;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) d[i] = 8'h00;

    clk_n(3);
    chk("rst_oe", 32'(sda_oe), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_wr_valid", 32'(wr_valid), 32'(0));
    chk("rst_wr_addr", 32'(wr_addr), 32'(0));
    chk("rst_wr_data", 32'(wr_data), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    rst = 1'b1;
    clk_n(5);

    // Out-of-range write: strobed and ACKed but not stored
    d[0] = 8'h10;
    wr_txn(8'h41, 1, d);
    rd_addr = 8'h41;
    #1;
    chk("oor_rd", 32'(rd_data), 32'(0));

    // Burst write then burst read back via repeated START
    d[0] = 8'hE0; d[1] = 8'h30; d[2] = 8'h61;
    wr_txn(8'h02, 3, d);
    chk_regs();
    rd_txn(1'b1, 8'h02, 3);

    // Foreign address: no ACK, no drive, no busy, no strobe
    base  = wq.size();
    oe0   = oe_cnt;
    busy0 = busy_cnt;
    bus_start();
    send_byte({7'h50, IIC_RW_WRITE}, a);
    chk("foreign_nack", 32'(a), 32'(1));
    send_byte(8'h03, a);
    send_byte(8'h99, a);
    bus_stop();
    chk("foreign_oe", 32'(oe_cnt - oe0), 32'(0));
    chk("foreign_busy", 32'(busy_cnt - busy0), 32'(0));
    chk("foreign_strobe", 32'(wq.size() - base), 32'(0));

    // Pointer wrap 0xFF -> 0x00 -> 0x01, checked by a current-address read
    d[0] = 8'hAA; d[1] = 8'h55;
    wr_txn(8'hFF, 2, d);
    chk("wrap_ptr_model", 32'(ptr), 32'(1));
    rd_txn(1'b0, 8'h00, 1);

    // Reset in the middle of a data byte
    base = wq.size();
    bus_start();
    send_byte({SA, IIC_RW_WRITE}, a);
    send_byte(8'h10, a);
    for (int i = 0; i < 4; i++) bit_out(1'b1, l);
    rst = 1'b0;
    clk_n(1);
    chk("midrst_oe", 32'(sda_oe), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    rst = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    ptr = 8'h00;
    for (int i = 0; i < 4; i++) bit_out(1'b1, l);
    bit_out(1'b1, a);
    chk("midrst_ignored", 32'(a), 32'(1));
    bus_stop();
    chk("midrst_strobe", 32'(wq.size() - base), 32'(0));
    d[0] = 8'h5A; d[1] = 8'hC3;
    wr_txn(8'h10, 2, d);
    rd_txn(1'b1, 8'h0F, 4);

    // Randomized write bursts, each read back
    for (int k = 0; k < 6; k++) begin
      logic [7:0] p;
      int         n;
      p = 8'($urandom_range(0, 70));
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      wr_txn(p, n, d);
      rd_txn(1'b1, p, n + 1);
    end
    chk_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
